// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared constants and state encoding for the fetch PC generator
package pc_gen_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    localparam int INST_ADDR_BUS_W = 32;

    typedef enum logic [1:0] {
        PC_BOOT = 2'b00,
        PC_RUN  = 2'b01,
        PC_HALT = 2'b10
    } pc_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-pc priority mux with branch alignment check
module pc_next_sel #(
    parameter int                ADDR_W     = 32,
    parameter int                INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(32'h0000_0020)
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              exc_req_i,
    input  logic              branch_req_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              hold_i,
    output logic [ADDR_W-1:0] next_pc_o,
    output logic              take_redirect_o,
    output logic              is_misaligned_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INST_BYTES);

    logic target_misaligned;

    assign target_misaligned = (branch_target_i & ALIGN_MASK) != '0;

    // Redirect sources first, then hold, then sequential advance (wraps naturally)
    always_comb begin
        next_pc_o       = pc_i + STEP;
        take_redirect_o = 1'b0;
        is_misaligned_o = 1'b0;
        if (exc_req_i) begin
            next_pc_o       = EXC_VECTOR;
            take_redirect_o = 1'b1;
        end else if (branch_req_i && target_misaligned) begin
            next_pc_o       = EXC_VECTOR;
            take_redirect_o = 1'b1;
            is_misaligned_o = 1'b1;
        end else if (branch_req_i) begin
            next_pc_o       = branch_target_i;
            take_redirect_o = 1'b1;
        end else if (hold_i) begin
            next_pc_o = pc_i;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program counter with redirect, stall and halt control
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W       = INST_ADDR_BUS_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'h0000_0000),
    parameter int                INST_BYTES   = 4,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'h0000_0020)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              fetch_ready,
    input  logic              branch_req,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              exc_req,
    input  logic              halt_req,
    input  logic              resume_req,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              fetch_valid,
    output logic              redirect,
    output logic              misalign,
    output logic [ADDR_W-1:0] bad_addr
);

    pc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              redirect_q, redirect_d;
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] bad_addr_q, bad_addr_d;

    logic [ADDR_W-1:0] sel_next_pc;
    logic              sel_redirect;
    logic              sel_misaligned;

    // A halt request freezes pc just like a stall; redirects still outrank it
    pc_next_sel #(
        .ADDR_W     (ADDR_W),
        .INST_BYTES (INST_BYTES),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_sel (
        .pc_i            (pc_q),
        .exc_req_i       (exc_req),
        .branch_req_i    (branch_req),
        .branch_target_i (branch_target),
        .hold_i          (stall | ~fetch_ready | halt_req),
        .next_pc_o       (sel_next_pc),
        .take_redirect_o (sel_redirect),
        .is_misaligned_o (sel_misaligned)
    );

    // Next-state and next-output logic for BOOT/RUN/HALT
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ce_d       = ce_q;
        redirect_d = 1'b0;
        misalign_d = 1'b0;
        bad_addr_d = bad_addr_q;
        case (state_q)
            PC_BOOT: begin
                state_d = PC_RUN;
                ce_d    = ChipEnable;
            end
            PC_RUN: begin
                pc_d       = sel_next_pc;
                redirect_d = sel_redirect;
                misalign_d = sel_misaligned;
                if (sel_misaligned) begin
                    bad_addr_d = branch_target;
                end
                if (halt_req && !sel_redirect) begin
                    state_d = PC_HALT;
                    ce_d    = ChipDisable;
                end
            end
            PC_HALT: begin
                if (exc_req) begin
                    state_d    = PC_RUN;
                    ce_d       = ChipEnable;
                    pc_d       = EXC_VECTOR;
                    redirect_d = 1'b1;
                end else if (resume_req) begin
                    state_d = PC_RUN;
                    ce_d    = ChipEnable;
                end
            end
            default: begin
                state_d = PC_BOOT;
                ce_d    = ChipDisable;
            end
        endcase
    end

    // State and output registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q    <= PC_BOOT;
            pc_q       <= RESET_VECTOR;
            ce_q       <= ChipDisable;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ce_q       <= ce_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    assign pc          = pc_q;
    assign ce          = ce_q;
    assign fetch_valid = ce_q;
    assign redirect    = redirect_q;
    assign misalign    = misalign_q;
    assign bad_addr    = bad_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard bench for pc_gen with a behavioural reference model
module tb_pc_gen;

    localparam logic [31:0] EXC = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rst, stall, fetch_ready, branch_req, exc_req, halt_req, resume_req;
    logic [31:0] branch_target;
    logic [31:0] pc, bad_addr;
    logic        ce, fetch_valid, redirect, misalign;

    logic        w_rst;
    logic        w_zero = 1'b0;
    logic        w_one  = 1'b1;
    logic [15:0] w_target = 16'h0000;
    logic [15:0] w_pc, w_bad_addr;
    logic        w_ce, w_fetch_valid, w_redirect, w_misalign;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk (clk), .rst (rst), .stall (stall), .fetch_ready (fetch_ready),
        .branch_req (branch_req), .branch_target (branch_target), .exc_req (exc_req),
        .halt_req (halt_req), .resume_req (resume_req), .pc (pc), .ce (ce),
        .fetch_valid (fetch_valid), .redirect (redirect), .misalign (misalign),
        .bad_addr (bad_addr)
    );

    pc_gen #(
        .ADDR_W (16), .RESET_VECTOR (16'hFFFC), .INST_BYTES (2), .EXC_VECTOR (16'h0020)
    ) dut_wrap (
        .clk (clk), .rst (w_rst), .stall (w_zero), .fetch_ready (w_one),
        .branch_req (w_zero), .branch_target (w_target), .exc_req (w_zero),
        .halt_req (w_zero), .resume_req (w_zero), .pc (w_pc), .ce (w_ce),
        .fetch_valid (w_fetch_valid), .redirect (w_redirect), .misalign (w_misalign),
        .bad_addr (w_bad_addr)
    );

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic        redir;
        logic        mis;
        logic [31:0] bad;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: 0 = booting, 1 = running, 2 = halted
    int          m_mode = 0;
    logic [31:0] m_pc   = 32'h0;
    logic        m_ce   = 1'b0;
    logic        m_red  = 1'b0;
    logic        m_mis  = 1'b0;
    logic [31:0] m_bad  = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic void model_step();
        if (rst) begin
            m_mode = 0; m_pc = 32'h0; m_ce = 1'b0; m_red = 1'b0; m_mis = 1'b0; m_bad = 32'h0;
            return;
        end
        m_red = 1'b0;
        m_mis = 1'b0;
        if (m_mode == 0) begin
            m_mode = 1; m_ce = 1'b1;
        end else if (m_mode == 1) begin
            if (exc_req) begin
                m_pc = EXC; m_red = 1'b1;
            end else if (branch_req && (branch_target % 4 != 0)) begin
                m_pc = EXC; m_red = 1'b1; m_mis = 1'b1; m_bad = branch_target;
            end else if (branch_req) begin
                m_pc = branch_target; m_red = 1'b1;
            end else if (halt_req) begin
                m_mode = 2; m_ce = 1'b0;
            end else if (!stall && fetch_ready) begin
                m_pc = m_pc + 32'd4;
            end
        end else begin
            if (exc_req) begin
                m_mode = 1; m_ce = 1'b1; m_pc = EXC; m_red = 1'b1;
            end else if (resume_req) begin
                m_mode = 1; m_ce = 1'b1;
            end
        end
    endfunction

    task automatic drive(input logic r, input logic st, input logic fr, input logic br,
                         input logic [31:0] tg, input logic ex, input logic ht, input logic rs);
        exp_t e;
        @(negedge clk);
        rst = r; stall = st; fetch_ready = fr; branch_req = br; branch_target = tg;
        exc_req = ex; halt_req = ht; resume_req = rs;
        model_step();
        e.pc = m_pc; e.ce = m_ce; e.redir = m_red; e.mis = m_mis; e.bad = m_bad;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1, 0, 32'h0, 0, 0, 0);
    endtask

    // Monitor: every presented output after an edge is matched against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", pc, e.pc);
                chk("ce", {31'b0, ce}, {31'b0, e.ce});
                chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, e.ce});
                chk("flags", {30'b0, redirect, misalign}, {30'b0, e.redir, e.mis});
                chk("bad_addr", bad_addr, e.bad);
            end
        end
    end

    task automatic wstep(input logic r, input logic [15:0] want_pc, input logic want_ce);
        @(negedge clk);
        w_rst = r;
        @(posedge clk);
        #1;
        chk("wrap_pc", {16'b0, w_pc}, {16'b0, want_pc});
        chk("wrap_ce", {31'b0, w_ce}, {31'b0, want_ce});
    endtask

    initial begin
        int sel;
        logic [31:0] tg;
        rst = 1; stall = 0; fetch_ready = 1; branch_req = 0; branch_target = 0;
        exc_req = 0; halt_req = 0; resume_req = 0; w_rst = 1;

        // Reset and boot, then sequential fetch up to 0x10
        for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 32'h0, 0, 0, 0);
        idle(5);
        // Stall twice, backpressure once, then advance
        drive(0, 1, 1, 0, 32'h0, 0, 0, 0);
        drive(0, 1, 1, 0, 32'h0, 0, 0, 0);
        drive(0, 0, 0, 0, 32'h0, 0, 0, 0);
        idle(1);
        // Branch vs exception, including redirect under stall
        drive(0, 0, 1, 1, 32'h40, 0, 0, 0);
        drive(0, 1, 0, 1, 32'h100, 0, 1, 0);
        drive(0, 0, 1, 1, 32'h40, 0, 0, 0);
        drive(0, 0, 1, 1, 32'h100, 1, 0, 0);
        // Misaligned target, bad_addr must persist
        drive(0, 0, 1, 1, 32'h102, 0, 0, 0);
        idle(3);
        // Halt at 0x30, resume, then halt again and leave via exception
        drive(0, 0, 1, 1, 32'h30, 0, 0, 0);
        drive(0, 0, 1, 0, 32'h0, 0, 1, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 1, 1, 32'h200, 0, 0, 0);
        drive(0, 0, 1, 0, 32'h0, 0, 0, 1);
        idle(1);
        drive(0, 0, 1, 0, 32'h0, 0, 1, 0);
        idle(2);
        drive(0, 0, 1, 0, 32'h0, 1, 0, 1);
        idle(1);
        // Wrap at the top of the 32-bit space
        drive(0, 0, 1, 1, 32'hFFFF_FFF8, 0, 0, 0);
        idle(3);
        // Reset while halted
        drive(0, 0, 1, 0, 32'h0, 0, 1, 0);
        drive(1, 0, 1, 0, 32'h0, 0, 0, 0);
        idle(2);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            sel = int'($urandom_range(0, 99));
            tg  = $urandom;
            if ($urandom_range(0, 3) != 0) tg[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) tg = 32'hFFFF_FFF4;
            drive(sel == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
                  (sel >= 1 && sel < 11), tg, (sel >= 11 && sel < 14),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0));
        end
        idle(1);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        // Wrap with 16-bit pc and two-byte instructions
        wstep(1, 16'hFFFC, 1'b0);
        wstep(1, 16'hFFFC, 1'b0);
        wstep(0, 16'hFFFC, 1'b1);
        wstep(0, 16'hFFFE, 1'b1);
        wstep(0, 16'h0000, 1'b1);
        wstep(0, 16'h0002, 1'b1);
        wstep(1, 16'hFFFC, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage. It is the next generation of the basic reset-then-increment PC.
- Adds a configurable reset vector, instruction step and width, and a fetch valid/ready handshake with pipeline stall.
- Adds branch and exception redirect with fixed priority, misaligned-target trapping, and a halt/resume state machine.
- Drives the instruction-memory address and chip enable; sits between the control/hazard unit and instruction memory.

Parameters:
ADDR_W, 32, width of pc and all address inputs
RESET_VECTOR, 32'h0000_0000, pc value held during reset and fetched first
INST_BYTES, 4, sequential increment; power of two, 1..8
EXC_VECTOR, 32'h0000_0020, trap target for exceptions and misaligned branches

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hold pc (hazard unit)
fetch_ready  in  1  instruction memory accepts current pc this cycle
branch_req  in  1  redirect to branch_target
branch_target  in  ADDR_W  branch/jump destination
exc_req  in  1  take exception, redirect to EXC_VECTOR
halt_req  in  1  enter HALT after current cycle
resume_req  in  1  leave HALT
pc  out  ADDR_W  current fetch address
ce  out  1  instruction memory chip enable
fetch_valid  out  1  pc is a valid fetch request
redirect  out  1  one-cycle pulse: pc was loaded non-sequentially (flush IF/ID)
misalign  out  1  one-cycle pulse: branch target was misaligned
bad_addr  out  ADDR_W  last misaligned branch target captured

Behaviour:
- Reset (rst=1 at edge):
  - state=BOOT, pc=RESET_VECTOR, ce=0, fetch_valid=0, redirect=0, misalign=0, bad_addr=0.
  - rst overrides every other input, including mid-redirect or in HALT.
- States: BOOT, RUN, HALT. Encoding is 2 bits.
- BOOT: first edge with rst=0 -> RUN, ce=1, fetch_valid=1, pc stays RESET_VECTOR. The first fetch is therefore RESET_VECTOR one cycle after reset release.
- RUN: pc update priority per edge, highest first:
  1. exc_req -> pc=EXC_VECTOR, redirect=1.
  2. branch_req with branch_target[log2(INST_BYTES)-1:0]!=0 -> pc=EXC_VECTOR, redirect=1, misalign=1, bad_addr=branch_target.
  3. branch_req, aligned -> pc=branch_target, redirect=1.
  4. halt_req -> state=HALT, pc held, ce=0, fetch_valid=0.
  5. stall=1 or fetch_ready=0 -> pc held.
  6. Otherwise -> pc = pc + INST_BYTES, modulo 2^ADDR_W.
- Redirects (1-3) are taken even when stall=1 or fetch_ready=0; the redirect cancels the pending fetch.
- Wrap: pc = 2^ADDR_W - INST_BYTES advances to 0 with no flag.
- halt_req together with a branch: the branch is taken and halt_req is ignored that cycle. The requester must hold halt_req.
- HALT: ce=0, fetch_valid=0, pc held.
  - resume_req -> RUN, ce=1, fetch_valid=1, pc unchanged.
  - exc_req in HALT -> RUN, pc=EXC_VECTOR, redirect=1; exception wins over resume_req.
  - branch_req and stall are ignored in HALT.
- redirect and misalign are registered and high for exactly one cycle after the causing edge; they are 0 otherwise.
- bad_addr holds its value until the next misalign or reset.
- fetch_valid equals ce at all times. pc is registered, with zero combinational path from inputs to outputs.

Decomposition:
- Shared defines header: RstEnable, ChipEnable/ChipDisable, state encodings (PC_BOOT, PC_RUN, PC_HALT), InstAddrBus width.
- One natural sub-module: pc_next_sel. It is combinational: priority mux plus alignment check, and outputs next_pc, take_redirect, is_misaligned.
- The parent holds the state machine and registers.

Test Plan (defaults unless stated):
- Reset/boot: rst=1 for 3 cycles, then 0, fetch_ready=1 -> ce=0 and pc=0 during reset. First cycle after release: ce=1, pc=0x0. Following cycles: 0x4, 0x8, 0xC.
- Stall/backpressure: at pc=0x10, stall=1 for 2 cycles, then fetch_ready=0 for 1 cycle -> pc stays 0x10 for 3 cycles, then 0x14.
- Branch vs exception: at pc=0x40, branch_req=1 with target 0x100 -> pc=0x100 and redirect pulses. Same cycle with exc_req=1 as well -> pc=0x20 instead.
- Misaligned branch: target 0x102 -> pc=0x20, misalign=1 for one cycle, bad_addr=0x102, and bad_addr holds 0x102 afterwards.
- Halt/resume: halt_req at pc=0x30 -> ce=0, pc=0x30 held for 5 cycles. resume_req -> ce=1, pc=0x30, then 0x34. Repeat with exc_req in HALT -> pc=0x20.
- Wrap/params: ADDR_W=16, INST_BYTES=2, RESET_VECTOR=16'hFFFC -> pc sequence FFFC, FFFE, 0000. Also rst asserted mid-sequence -> next pc=FFFC, ce=0.
